// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone command master: response status codes and FSM states.
package wb_master_pkg;

    localparam int RETRY_W = 2;

    typedef enum logic [1:0] {
        RSP_OK            = 2'd0,
        RSP_ERR           = 2'd1,
        RSP_RTY_EXHAUSTED = 2'd2,
        RSP_TIMEOUT       = 2'd3
    } rsp_status_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_BACKOFF = 2'd2,
        S_RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone bus bundle between the command decoder, the master and the peripheral bus.
interface wb_cmd_master_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_we;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [SELECT_WIDTH-1:0] cmd_sel;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic [1:0]              rsp_status;
    logic [1:0]              rsp_retries;
    logic                    busy;

    logic [ADDR_WIDTH-1:0]   wbm_adr_o;
    logic [DATA_WIDTH-1:0]   wbm_dat_o;
    logic [DATA_WIDTH-1:0]   wbm_dat_i;
    logic                    wbm_we_o;
    logic [SELECT_WIDTH-1:0] wbm_sel_o;
    logic                    wbm_stb_o;
    logic                    wbm_cyc_o;
    logic                    wbm_ack_i;
    logic                    wbm_err_i;
    logic                    wbm_rty_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel, rsp_ready,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_status, rsp_retries, busy,
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel, rsp_ready,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_status, rsp_retries, busy,
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
    );

endinterface

// File: rtl/wb_timeout_counter.sv
// Clear/enable cycle counter; tc flags the last cycle of a TIMEOUT_CYCLES window.
// Latency: tc is decoded from the count register, so it is valid in the same cycle.
// Backpressure: none; en pauses counting, clr restarts it.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST = LAST_I[CNT_W-1:0];

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

    // A zero-length window disables the abort entirely.
    assign tc = (TIMEOUT_CYCLES != 0) && (count == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one valid/ready command becomes one bus read/write with retry and timeout.
// Latency: stb rises at the accept edge; response valid one edge after the termination is sampled.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready, blocking new commands.
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRY      = 3
) (
    input logic             clk,
    input logic             rst,
    wb_cmd_master_if.master bus
);
    state_t                  state_q, state_d;
    logic                    strobe_q, strobe_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    rsp_status_t             status_q, status_d;
    logic [RETRY_W-1:0]      retries_q, retries_d;
    logic [RETRY_W-1:0]      retry_cnt_q, retry_cnt_d;
    logic                    busy_q;
    logic                    tmo_clr, tmo_en, tmo_tc;
    logic                    done;
    rsp_status_t             done_status;
    logic                    accept;

    assign bus.cmd_ready = (state_q == S_IDLE) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (tmo_clr),
        .en  (tmo_en),
        .tc  (tmo_tc)
    );

    always_comb begin
        state_d     = state_q;
        strobe_d    = strobe_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        status_d    = status_q;
        retries_d   = retries_q;
        retry_cnt_d = retry_cnt_q;
        tmo_clr     = 1'b0;
        tmo_en      = 1'b0;
        done        = 1'b0;
        done_status = RSP_OK;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d        = bus.cmd_we;
                    adr_d       = bus.cmd_addr;
                    dat_d       = bus.cmd_wdata;
                    sel_d       = bus.cmd_sel;
                    strobe_d    = 1'b1;
                    retry_cnt_d = '0;
                    tmo_clr     = 1'b1;
                    state_d     = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // Termination priority is ack > err > rty; timeout only counts idle bus cycles.
                if (bus.wbm_ack_i) begin
                    done        = 1'b1;
                    done_status = RSP_OK;
                end else if (bus.wbm_err_i) begin
                    done        = 1'b1;
                    done_status = RSP_ERR;
                end else if (bus.wbm_rty_i) begin
                    if (int'(retry_cnt_q) < MAX_RETRY) begin
                        strobe_d    = 1'b0;
                        retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                        state_d     = S_BACKOFF;
                    end else begin
                        done        = 1'b1;
                        done_status = RSP_RTY_EXHAUSTED;
                    end
                end else if (tmo_tc) begin
                    done        = 1'b1;
                    done_status = RSP_TIMEOUT;
                end else begin
                    tmo_en = 1'b1;
                end

                if (done) begin
                    strobe_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    status_d    = done_status;
                    retries_d   = retry_cnt_q;
                    rdata_d     = (done_status == RSP_OK && !we_q) ? bus.wbm_dat_i : '0;
                    state_d     = S_RESP;
                end
            end
            S_BACKOFF: begin
                strobe_d = 1'b1;
                tmo_clr  = 1'b1;
                state_d  = S_ACTIVE;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            strobe_q    <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            status_q    <= RSP_OK;
            retries_q   <= '0;
            retry_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            strobe_q    <= strobe_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
            retries_q   <= retries_d;
            retry_cnt_q <= retry_cnt_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign bus.wbm_cyc_o   = strobe_q;
    assign bus.wbm_stb_o   = strobe_q;
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_adr_o   = adr_q;
    assign bus.wbm_dat_o   = dat_q;
    assign bus.wbm_sel_o   = sel_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_status  = status_q;
    assign bus.rsp_retries = retries_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: behavioural register slave with selectable termination, scoreboard on the response channel.
module tb_wb_cmd_master;

    localparam int M_ACK    = 0;
    localparam int M_ERR    = 1;
    localparam int M_ACKERR = 2;
    localparam int M_RTY    = 3;
    localparam int M_NONE   = 4;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    int smode     = M_ACK;
    int rty_limit = 0;
    int rty_cnt   = 0;
    logic [31:0] mem [0:3] = '{32'h0, 32'h0, 32'h0, 32'h0};

    logic [35:0] exp_q [$];

    int   cyc_cycles     = 0;
    int   backoff_cycles = 0;
    int   stb_rises      = 0;
    int   we_cycles      = 0;
    logic stb_prev       = 1'b0;

    always #5 clk = ~clk;

    wb_cmd_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) bus ();
    wb_cmd_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) bus1 ();

    wb_cmd_master #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT_CYCLES(8), .MAX_RETRY(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_cmd_master #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT_CYCLES(0), .MAX_RETRY(3)
    ) dut_notmo (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Registered-ack slave: answers one cycle after seeing stb, one termination per strobe phase.
    always @(posedge clk) begin
        bus.wbm_ack_i <= 1'b0;
        bus.wbm_err_i <= 1'b0;
        bus.wbm_rty_i <= 1'b0;
        bus.wbm_dat_i <= '0;
        if (!bus.busy) rty_cnt <= 0;
        if (bus.wbm_cyc_o && bus.wbm_stb_o && !(bus.wbm_ack_i || bus.wbm_err_i || bus.wbm_rty_i)) begin
            if (smode == M_ERR) begin
                bus.wbm_err_i <= 1'b1;
            end else if (smode == M_RTY && rty_cnt < rty_limit) begin
                bus.wbm_rty_i <= 1'b1;
                rty_cnt       <= rty_cnt + 1;
            end else if (smode != M_NONE) begin
                bus.wbm_ack_i <= 1'b1;
                bus.wbm_err_i <= (smode == M_ACKERR);
                if (bus.wbm_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.wbm_sel_o[b]) mem[bus.wbm_adr_o[3:2]][8*b +: 8] <= bus.wbm_dat_o[8*b +: 8];
                end else begin
                    bus.wbm_dat_i <= mem[bus.wbm_adr_o[3:2]];
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc_cycles     <= cyc_cycles + (bus.wbm_cyc_o ? 1 : 0);
        backoff_cycles <= backoff_cycles + ((bus.busy && !bus.wbm_cyc_o && !bus.rsp_valid) ? 1 : 0);
        stb_rises      <= stb_rises + ((bus.wbm_stb_o && !stb_prev) ? 1 : 0);
        we_cycles      <= we_cycles + ((bus.wbm_stb_o && bus.wbm_we_o) ? 1 : 0);
        stb_prev       <= bus.wbm_stb_o;
    end

    // Scoreboard monitor: compares every accepted response against the oldest expectation.
    always @(negedge clk) begin
        logic [35:0] e;
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got response 0x%0h, required none",
                         {bus.rsp_rdata, bus.rsp_status, bus.rsp_retries});
            end else begin
                e = exp_q.pop_front();
                chk("rsp{rdata,status,retries}", 64'({bus.rsp_rdata, bus.rsp_status, bus.rsp_retries}), 64'(e));
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int i;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_sel   = s;
        i = 0;
        while (!bus.cmd_ready && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("cmd_ready", 64'(bus.cmd_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.rsp_valid) break;
        end
        chk("rsp_seen", 64'(bus.rsp_valid), 64'(1));
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (bus.busy && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("idle_reached", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int lat, c0, b0, s0, w0, cnt;
        logic [35:0] cap;

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_sel = '0;
        bus.rsp_ready = 1'b1;
        bus1.cmd_valid = 1'b0; bus1.cmd_we = 1'b0; bus1.cmd_addr = '0; bus1.cmd_wdata = '0; bus1.cmd_sel = '0;
        bus1.rsp_ready = 1'b1; bus1.wbm_dat_i = '0;
        bus1.wbm_ack_i = 1'b0; bus1.wbm_err_i = 1'b0; bus1.wbm_rty_i = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        chk("reset_ctrl", 64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.rsp_valid, bus.busy}), 64'(0));
        chk("reset_adr_sel", 64'({bus.wbm_adr_o, bus.wbm_sel_o}), 64'(0));
        chk("reset_rsp", 64'({bus.rsp_rdata, bus.rsp_status, bus.rsp_retries}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));

        // Write 5 to 0x00, then read it back.
        smode = M_ACK; s0 = stb_rises;
        exp_q.push_back({32'h0, 2'd0, 2'd0});
        issue(1'b1, 32'h0, 32'h5, 4'hF);
        wait_rsp(lat);
        chk("write_latency", 64'(lat), 64'(2));
        wait_idle();
        chk("write_stb_pulses", 64'(stb_rises - s0), 64'(1));
        chk("write_slave_reg", 64'(mem[0]), 64'(32'h5));

        w0 = we_cycles;
        exp_q.push_back({32'h5, 2'd0, 2'd0});
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        wait_rsp(lat);
        wait_idle();
        chk("read_we_low", 64'(we_cycles - w0), 64'(0));

        // Partial byte-select write then read.
        exp_q.push_back({32'h0, 2'd0, 2'd0});
        issue(1'b1, 32'h4, 32'hAABBCCDD, 4'h3);
        wait_rsp(lat); wait_idle();
        exp_q.push_back({32'h0000CCDD, 2'd0, 2'd0});
        issue(1'b0, 32'h4, 32'h0, 4'hF);
        wait_rsp(lat); wait_idle();

        // Two retries then ack.
        smode = M_RTY; rty_limit = 2; b0 = backoff_cycles; s0 = stb_rises;
        exp_q.push_back({32'h5, 2'd0, 2'd2});
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        wait_rsp(lat); wait_idle();
        chk("rty2_backoff_cycles", 64'(backoff_cycles - b0), 64'(2));
        chk("rty2_stb_pulses", 64'(stb_rises - s0), 64'(3));

        // Retry forever: exhausted after three reissues.
        rty_limit = 1000; b0 = backoff_cycles;
        exp_q.push_back({32'h0, 2'd2, 2'd3});
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        wait_rsp(lat); wait_idle();
        chk("rty_exh_backoff_cycles", 64'(backoff_cycles - b0), 64'(3));

        // Silent slave with an 8-cycle window.
        smode = M_NONE; c0 = cyc_cycles;
        exp_q.push_back({32'h0, 2'd3, 2'd0});
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        wait_rsp(lat); wait_idle();
        chk("timeout_cyc_cycles", 64'(cyc_cycles - c0), 64'(8));

        // ack wins over err; err alone reports ERR with zero data.
        smode = M_ACKERR;
        exp_q.push_back({32'h5, 2'd0, 2'd0});
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        wait_rsp(lat); wait_idle();
        smode = M_ERR;
        exp_q.push_back({32'h0, 2'd1, 2'd0});
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        wait_rsp(lat); wait_idle();

        // Consumer stalls the response for five cycles.
        smode = M_ACK;
        @(posedge clk); #1; bus.rsp_ready = 1'b0;
        exp_q.push_back({32'h5, 2'd0, 2'd0});
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        wait_rsp(lat);
        cap = {bus.rsp_rdata, bus.rsp_status, bus.rsp_retries};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", 64'({bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata, bus.rsp_status, bus.rsp_retries}),
                64'({1'b1, 1'b0, cap}));
        end
        @(posedge clk); #1; bus.rsp_ready = 1'b1;
        wait_idle();

        // Reset in the middle of an active cycle drops the bus and the pending response.
        smode = M_NONE;
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_bus", 64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, bus.busy}), 64'(0));
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midreset_idle", 64'({bus.busy, bus.rsp_valid, bus.cmd_ready}), 64'(3'b001));
        smode = M_ACK;
        exp_q.push_back({32'h0, 2'd0, 2'd0});
        issue(1'b1, 32'h8, 32'h1234, 4'hF);
        wait_rsp(lat);
        chk("post_reset_latency", 64'(lat), 64'(2));
        wait_idle();
        exp_q.push_back({32'h1234, 2'd0, 2'd0});
        issue(1'b0, 32'h8, 32'h0, 4'hF);
        wait_rsp(lat); wait_idle();

        // Timeout disabled: strobe held for 1000 cycles against a silent slave.
        @(negedge clk);
        bus1.cmd_valid = 1'b1; bus1.cmd_we = 1'b0; bus1.cmd_addr = 32'h10; bus1.cmd_sel = 4'hF;
        chk("notmo_cmd_ready", 64'(bus1.cmd_ready), 64'(1));
        @(posedge clk); #1; bus1.cmd_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus1.wbm_stb_o && bus1.wbm_cyc_o && !bus1.rsp_valid) cnt++;
        end
        chk("notmo_stb_cycles", 64'(cnt), 64'(1000));

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic single-cycle initiator.
- Turns a valid/ready command from the SPI command decoder into one Wishbone read or write on the peripheral bus (LED controller, PWM, and similar slaves).
- Returns read data plus a status code on a valid/ready response channel.
- Handles ack, err and rty terminations, bounded retry, and a timeout for slaves that never respond.

Parameters:
- DATA_WIDTH, 32, bus data width.
- ADDR_WIDTH, 32, bus address width.
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT_CYCLES, 256, max cycles waiting in ACTIVE before abort; 0 disables the timeout.
- MAX_RETRY, 3, number of reissues allowed after rty.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_we  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_sel  in  SELECT_WIDTH  byte selects
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and failures
- rsp_status  out  2  0=OK, 1=ERR, 2=RTY_EXHAUSTED, 3=TIMEOUT
- rsp_retries  out  2  number of rty reissues used
- busy  out  1  high whenever state is not IDLE
- wbm_adr_o  out  ADDR_WIDTH
- wbm_dat_o  out  DATA_WIDTH
- wbm_dat_i  in  DATA_WIDTH
- wbm_we_o  out  1
- wbm_sel_o  out  SELECT_WIDTH
- wbm_stb_o  out  1
- wbm_cyc_o  out  1
- wbm_ack_i  in  1
- wbm_err_i  in  1
- wbm_rty_i  in  1

Behaviour:
- Clocking and reset:
  - Single clock clk; rst is synchronous, active-high.
  - On reset: state IDLE; cyc, stb, we, rsp_valid, busy = 0; adr, dat_o, sel, rsp_rdata, rsp_status, rsp_retries, retry count and timeout count = 0.
  - Reset mid-operation: cyc/stb drop at the reset edge and any pending response is discarded.
- Output registering: all outputs are registered; cmd_ready = (state==IDLE) && !rst.
- States: IDLE, ACTIVE, BACKOFF, RESP.
- IDLE:
  - On cmd_valid && cmd_ready, latch we/addr/wdata/sel into the bus output regs.
  - Set cyc=stb=1, clear retry and timeout counters, go to ACTIVE.
- ACTIVE: sample terminations each cycle with priority ack > err > rty.
  - ack: rsp_rdata = we ? 0 : wbm_dat_i; status OK; cyc=stb=0; go to RESP.
  - err: rdata 0; status ERR; cyc=stb=0; go to RESP.
  - rty with retries < MAX_RETRY: cyc=stb=0; increment retries; go to BACKOFF.
  - rty with retries == MAX_RETRY: status RTY_EXHAUSTED; go to RESP.
  - No termination: timeout counter increments. When it reaches TIMEOUT_CYCLES-1 (nonzero parameter), status TIMEOUT, cyc=stb=0, go to RESP.
- BACKOFF:
  - Exactly one cycle with cyc=stb=0.
  - Reassert cyc=stb with the same latched command, clear the timeout counter, return to ACTIVE.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On the handshake, rsp_valid=0 and go to IDLE.
- Termination inputs:
  - ack/err/rty are ignored outside ACTIVE. Slaves with registered ack, which keep ack high one cycle after stb drops, are therefore tolerated.
  - RESP+IDLE guarantee at least 2 cycles between a termination and the next stb.
- Latency: command accepted at edge N; stb is high from N. A registered-ack slave acks at N+1, and rsp_valid is high after edge N+2.
- rsp_retries reports the rty count for every status.
- Addresses and data are passed unmodified; no alignment check.

Decomposition:
- wb_master_pkg holds the rsp_status_t enum (OK/ERR/RTY_EXHAUSTED/TIMEOUT) and the state_t enum.
- Sub-module wb_timeout_counter provides a clear/enable counter with a terminal-count output, parameterised by TIMEOUT_CYCLES; 0 means it never fires.

Test Plan:
- Write 0x5, sel=0xF, to 0x00 on a wb_led_controller slave -> one stb pulse; rsp_status=0, rdata=0, rsp_valid after edge N+2; led_out=~4'h5.
- Read 0x00 after that write -> rsp_rdata=0x00000005, status 0, we_o=0 during the cycle.
- Slave asserts rty twice then ack -> two BACKOFF cycles with cyc=0; rsp_status=0, rsp_retries=2. With rty forever -> status 2, retries=3.
- Slave never responds, TIMEOUT_CYCLES=8 -> cyc high exactly 8 cycles; status 3; rdata 0. With TIMEOUT_CYCLES=0, stb stays high for 1000 cycles.
- Simultaneous ack+err -> status 0. err alone -> status 1. Hold rsp_ready=0 for 5 cycles -> rsp fields stable and cmd_ready=0 throughout.
- Assert rst for one cycle mid-ACTIVE -> cyc/stb=0 after that edge, no rsp_valid; next command completes normally.
